statistic_gen: RTL and testbench
================================

STATISTIC_GEN -- requirements
Module: statistic_gen

Interface
REQ-001 SHALL have parameter NCH, default 4, number of input data channels (1..16).
REQ-002 SHALL have parameter DW, default 8, data width per channel (2..32).
REQ-003 SHALL have parameter CW, default 16, counter width (CW >= 4).
REQ-004 SHALL have parameter SATURATE, default 0; 0 = counters wrap, 1 = counters saturate at 2^CW-1.
REQ-005 SHALL have parameter CLR_ON_SNAP, default 0; 1 = snapshot capture also zeroes live counters.
REQ-006 clock  input  1  single clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous reset, active-high.
REQ-008 clear  input  1  synchronous clear of counters and overflow when high.
REQ-009 valid  input  NCH  per-channel qualifier; bit i gates channel i.
REQ-010 data  input  NCH*DW  channel i occupies bits [i*DW +: DW].
REQ-011 pattern_a, pattern_b  input  DW each  programmable match patterns.
REQ-012 even_count  output  CW  registered count of qualified words with even parity.
REQ-013 match_count  output  CW  registered count of qualified words equal to pattern_a or pattern_b.
REQ-014 overflow  output  1  sticky; high once either counter overflows, until clear/reset.
REQ-015 snap_req  input  1  request snapshot; snap_ack  input  1  consumer acknowledge.
REQ-016 snap_valid  output  1; snap_even, snap_match  output  CW each; snap_ovf  output  1.

Function
REQ-017 Channel i SHALL contribute one even-parity hit when valid[i]=1 and XOR-reduction of its data is 0.
REQ-018 Channel i SHALL contribute one match hit when valid[i]=1 and data equals pattern_a or pattern_b; equal patterns count once.
REQ-019 Per cycle, hits SHALL be summed across channels (0..NCH) and added to the counter at the same edge; latency 1 cycle from input to output.
REQ-020 Wrap mode: counter SHALL take (count+hits) mod 2^CW; overflow set when the true sum exceeds 2^CW-1.
REQ-021 Saturate mode: counter SHALL hold 2^CW-1 when the true sum exceeds it; overflow set likewise; once saturated, overflow SHALL stay set.
REQ-022 Priority: reset > clear > counting; clear zeroes even_count, match_count, overflow and discards that cycle's hits.
REQ-023 Snapshot FSM SHALL have states IDLE and HOLD; IDLE --snap_req--> HOLD; HOLD --snap_ack--> IDLE.
REQ-024 On IDLE->HOLD edge, snap_even/snap_match/snap_ovf SHALL capture the pre-update live values and snap_valid SHALL assert next cycle and hold until the ack edge.
REQ-025 snap_req in HOLD SHALL be ignored; snap_ack in IDLE SHALL be ignored; snap outputs SHALL stay stable in HOLD.
REQ-026 snap_req and clear in the same cycle: snapshot captures pre-clear values, live counters clear.
REQ-027 CLR_ON_SNAP=1: live counters and overflow SHALL zero on the capture edge, that cycle's hits discarded.
REQ-028 Live counting SHALL continue unaffected while in HOLD.

Reset
REQ-029 On reset: even_count, match_count, overflow, snap_even, snap_match, snap_ovf = 0; snap_valid = 0; FSM = IDLE.
REQ-030 Reset in HOLD SHALL abandon the snapshot immediately (snap_valid low next cycle).

Structure
REQ-031 Shared package stat_pkg SHALL hold parameter defaults and the snapshot FSM state enum.
REQ-032 Per-channel classification plus hit summation SHALL be one sub-module, stat_hit_sum (NCH, DW params; outputs two sums of width clog2(NCH+1)).

Verification
REQ-033 NCH=4,DW=8,CW=8: all valid, data {0x00,0x03,0x01,0x55}, patterns 0x55/0xAA, 1 cycle -> even_count=3, match_count=1.
REQ-034 Wrap, CW=8: even_count=254, 4 even hits -> even_count=2, overflow=1, stays 1 until clear.
REQ-035 SATURATE=1: even_count=253, 4 even hits -> even_count=255, overflow=1; further hits hold 255.
REQ-036 valid=4'b0000 with matching data for 10 cycles -> both counters unchanged.
REQ-037 even_count=7, snap_req+clear same cycle -> snap_even=7, snap_valid=1 next cycle, even_count=0; second snap_req ignored until snap_ack.
REQ-038 reset asserted in HOLD with counters at 5 -> next cycle all outputs 0, snap_valid=0.

Source files
------------

// File: rtl/stat_pkg.sv
// ---------------------------------------------------------------------------
// stat_pkg : shared defaults and snapshot FSM state encoding for statistic_gen
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package stat_pkg;

  localparam int NCH_DEF         = 4;
  localparam int DW_DEF          = 8;
  localparam int CW_DEF          = 16;
  localparam int SATURATE_DEF    = 0;
  localparam int CLR_ON_SNAP_DEF = 0;

  typedef enum logic [0:0] {
    SNAP_IDLE = 1'b0,
    SNAP_HOLD = 1'b1
  } snap_state_e;

endpackage

`default_nettype wire

// File: rtl/stat_hit_sum.sv
// ---------------------------------------------------------------------------
// stat_hit_sum : per-channel even-parity / pattern-match classification and
//                hit summation across all channels
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stat_hit_sum
  import stat_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF,
  parameter int SW  = $clog2(NCH + 1)
) (
  input  logic [NCH-1:0]    valid_i,
  input  logic [NCH*DW-1:0] data_i,
  input  logic [DW-1:0]     pattern_a_i,
  input  logic [DW-1:0]     pattern_b_i,
  output logic [SW-1:0]     even_sum_o,
  output logic [SW-1:0]     match_sum_o
);

  logic [NCH-1:0] even_hit;
  logic [NCH-1:0] match_hit;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      // A word equal to both patterns is still a single hit.
      assign even_hit[i]  = valid_i[i] & ~(^data_i[i*DW +: DW]);
      assign match_hit[i] = valid_i[i] & ((data_i[i*DW +: DW] == pattern_a_i) ||
                                          (data_i[i*DW +: DW] == pattern_b_i));
    end
  endgenerate

  always_comb begin
    even_sum_o  = '0;
    match_sum_o = '0;
    for (int i = 0; i < NCH; i++) begin
      even_sum_o  = even_sum_o  + SW'(even_hit[i]);
      match_sum_o = match_sum_o + SW'(match_hit[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/statistic_gen.sv
// ---------------------------------------------------------------------------
// statistic_gen : even-parity and pattern-match word counters with sticky
//                 overflow and an acknowledged snapshot register set
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module statistic_gen
  import stat_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int DW          = DW_DEF,
  parameter int CW          = CW_DEF,
  parameter int SATURATE    = SATURATE_DEF,
  parameter int CLR_ON_SNAP = CLR_ON_SNAP_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic [NCH-1:0]    valid_i,
  input  logic [NCH*DW-1:0] data_i,
  input  logic [DW-1:0]     pattern_a_i,
  input  logic [DW-1:0]     pattern_b_i,
  output logic [CW-1:0]     even_count_o,
  output logic [CW-1:0]     match_count_o,
  output logic              overflow_o,
  input  logic              snap_req_i,
  input  logic              snap_ack_i,
  output logic              snap_valid_o,
  output logic [CW-1:0]     snap_even_o,
  output logic [CW-1:0]     snap_match_o,
  output logic              snap_ovf_o
);

  localparam int SW = $clog2(NCH + 1);
  localparam int EW = CW + 1;

  logic [SW-1:0] even_hits;
  logic [SW-1:0] match_hits;

  stat_hit_sum #(
    .NCH (NCH),
    .DW  (DW),
    .SW  (SW)
  ) u_hit_sum (
    .valid_i     (valid_i),
    .data_i      (data_i),
    .pattern_a_i (pattern_a_i),
    .pattern_b_i (pattern_b_i),
    .even_sum_o  (even_hits),
    .match_sum_o (match_hits)
  );

  logic [CW-1:0] even_q, even_d;
  logic [CW-1:0] match_q, match_d;
  logic          ovf_q, ovf_d;
  snap_state_e   state_q, state_d;
  logic [CW-1:0] snap_even_q, snap_match_q;
  logic          snap_ovf_q;

  logic [EW-1:0] even_sum;
  logic [EW-1:0] match_sum;
  logic          capture;
  logic          live_clr;

  // One extra bit holds the true sum so the carry flags overflow.
  assign even_sum  = {1'b0, even_q}  + EW'(even_hits);
  assign match_sum = {1'b0, match_q} + EW'(match_hits);

  assign capture  = (state_q == SNAP_IDLE) && snap_req_i;
  assign live_clr = clear_i || ((CLR_ON_SNAP != 0) && capture);

  always_comb begin
    even_d  = even_sum[CW-1:0];
    match_d = match_sum[CW-1:0];
    ovf_d   = ovf_q | even_sum[CW] | match_sum[CW];
    if (SATURATE != 0) begin
      if (even_sum[CW])  even_d  = '1;
      if (match_sum[CW]) match_d = '1;
    end
    if (live_clr) begin
      even_d  = '0;
      match_d = '0;
      ovf_d   = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SNAP_IDLE: if (snap_req_i) state_d = SNAP_HOLD;
      SNAP_HOLD: if (snap_ack_i) state_d = SNAP_IDLE;
      default:   state_d = SNAP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      even_q       <= '0;
      match_q      <= '0;
      ovf_q        <= 1'b0;
      state_q      <= SNAP_IDLE;
      snap_even_q  <= '0;
      snap_match_q <= '0;
      snap_ovf_q   <= 1'b0;
    end else begin
      even_q  <= even_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      if (capture) begin
        snap_even_q  <= even_q;
        snap_match_q <= match_q;
        snap_ovf_q   <= ovf_q;
      end
    end
  end

  assign even_count_o  = even_q;
  assign match_count_o = match_q;
  assign overflow_o    = ovf_q;
  assign snap_valid_o  = (state_q == SNAP_HOLD);
  assign snap_even_o   = snap_even_q;
  assign snap_match_o  = snap_match_q;
  assign snap_ovf_o    = snap_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_statistic_gen.sv
// ---------------------------------------------------------------------------
// tb_statistic_gen : directed bench for statistic_gen in wrap, saturate and
//                    clear-on-snapshot configurations driven in parallel
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_statistic_gen;

  logic        clk = 1'b0;
  logic        rst, clear, snap_req, snap_ack;
  logic [3:0]  valid;
  logic [31:0] data;
  logic [7:0]  pa, pb;

  logic [7:0] ew, mw, sew, smw, es, ms, ses, sms, ec, mc, sec, smc;
  logic       ow, sow, svw, os, sos, svs, oc, soc, svc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  statistic_gen #(.NCH(4), .DW(8), .CW(8), .SATURATE(0), .CLR_ON_SNAP(0)) dut_w (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .valid_i(valid), .data_i(data),
    .pattern_a_i(pa), .pattern_b_i(pb), .even_count_o(ew), .match_count_o(mw),
    .overflow_o(ow), .snap_req_i(snap_req), .snap_ack_i(snap_ack),
    .snap_valid_o(svw), .snap_even_o(sew), .snap_match_o(smw), .snap_ovf_o(sow));

  statistic_gen #(.NCH(4), .DW(8), .CW(8), .SATURATE(1), .CLR_ON_SNAP(0)) dut_s (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .valid_i(valid), .data_i(data),
    .pattern_a_i(pa), .pattern_b_i(pb), .even_count_o(es), .match_count_o(ms),
    .overflow_o(os), .snap_req_i(snap_req), .snap_ack_i(snap_ack),
    .snap_valid_o(svs), .snap_even_o(ses), .snap_match_o(sms), .snap_ovf_o(sos));

  statistic_gen #(.NCH(4), .DW(8), .CW(8), .SATURATE(0), .CLR_ON_SNAP(1)) dut_c (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .valid_i(valid), .data_i(data),
    .pattern_a_i(pa), .pattern_b_i(pb), .even_count_o(ec), .match_count_o(mc),
    .overflow_o(oc), .snap_req_i(snap_req), .snap_ack_i(snap_ack),
    .snap_valid_o(svc), .snap_even_o(sec), .snap_match_o(smc), .snap_ovf_o(soc));

  typedef struct {
    logic        clr;
    logic [3:0]  v;
    logic [31:0] d;
    logic [7:0]  pa;
    logic [7:0]  pb;
    logic [7:0]  ee;
    logic [7:0]  em;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled one falling edge later.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // Cumulative expected counts; data packed {ch3,ch2,ch1,ch0}.
    tbl[0] = '{1'b0, 4'hF, 32'h55010300, 8'h55, 8'hAA, 8'd3, 8'd1};
    tbl[1] = '{1'b0, 4'hF, 32'hAA5555AA, 8'h55, 8'hAA, 8'd7, 8'd5};
    tbl[2] = '{1'b0, 4'h0, 32'h55555555, 8'h55, 8'hAA, 8'd7, 8'd5};
    tbl[3] = '{1'b0, 4'h5, 32'h55FFAA07, 8'h55, 8'hAA, 8'd8, 8'd5};
    tbl[4] = '{1'b1, 4'hF, 32'h55AA0003, 8'h55, 8'hAA, 8'd0, 8'd0};
    tbl[5] = '{1'b0, 4'hF, 32'h80070180, 8'h55, 8'hAA, 8'd0, 8'd0};
    tbl[6] = '{1'b0, 4'hF, 32'h3C3C3C3C, 8'h3C, 8'h3C, 8'd4, 8'd4};
    tbl[7] = '{1'b0, 4'h8, 32'h3C000000, 8'h3C, 8'h00, 8'd5, 8'd5};

    rst = 1'b1; clear = 1'b0; snap_req = 1'b0; snap_ack = 1'b0;
    valid = 4'h0; data = 32'h0; pa = 8'h55; pb = 8'hAA;
    tick(); tick();
    chk("rst_even", ew, 0);
    chk("rst_match", mw, 0);
    chk("rst_ovf", ow, 0);
    chk("rst_snap_valid", svw, 0);
    chk("rst_snap_even", sew, 0);
    chk("rst_snap_ovf", sow, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      clear = tbl[i].clr; valid = tbl[i].v; data = tbl[i].d;
      pa = tbl[i].pa; pb = tbl[i].pb;
      tick();
      chk($sformatf("v%0d_even_w", i), ew, tbl[i].ee);
      chk($sformatf("v%0d_match_w", i), mw, tbl[i].em);
      chk($sformatf("v%0d_ovf_w", i), ow, 0);
      chk($sformatf("v%0d_even_s", i), es, tbl[i].ee);
      chk($sformatf("v%0d_match_s", i), ms, tbl[i].em);
      chk($sformatf("v%0d_even_c", i), ec, tbl[i].ee);
      chk($sformatf("v%0d_match_c", i), mc, tbl[i].em);
    end

    // Counter boundary: reach exactly 255, then cross it.
    pa = 8'h55; pb = 8'hAA;
    clear = 1'b1; valid = 4'h0; data = 32'h0; tick();
    clear = 1'b0; valid = 4'hF;
    repeat (63) tick();
    valid = 4'h7; tick();
    chk("max_even_w", ew, 255);
    chk("max_ovf_w", ow, 0);
    chk("max_even_s", es, 255);
    chk("max_ovf_s", os, 0);
    valid = 4'h1; tick();
    chk("wrap_even_w", ew, 0);
    chk("wrap_ovf_w", ow, 1);
    chk("sat_even_s", es, 255);
    chk("sat_ovf_s", os, 1);
    valid = 4'hF; tick();
    chk("wrap2_even_w", ew, 4);
    chk("sat2_even_s", es, 255);
    valid = 4'h0; data = 32'h55555555;
    repeat (10) tick();
    chk("idle_even_w", ew, 4);
    chk("idle_match_w", mw, 0);
    chk("idle_ovf_w", ow, 1);
    chk("idle_even_s", es, 255);
    chk("idle_ovf_s", os, 1);
    snap_req = 1'b1; tick();
    chk("ovsnap_ovf_w", sow, 1);
    chk("ovsnap_even_w", sew, 4);
    chk("ovsnap_valid_w", svw, 1);
    chk("ovsnap_live_ovf_w", ow, 1);
    chk("ovsnap_ovf_s", sos, 1);
    chk("ovsnap_even_s", ses, 255);
    chk("ovsnap_ovf_c", soc, 1);
    chk("ovsnap_live_even_c", ec, 0);
    chk("ovsnap_live_ovf_c", oc, 0);
    snap_req = 1'b0; snap_ack = 1'b1; tick();
    snap_ack = 1'b0;
    clear = 1'b1; tick();
    clear = 1'b0;
    chk("clr_even_w", ew, 0);
    chk("clr_ovf_w", ow, 0);
    chk("clr_even_s", es, 0);
    chk("clr_ovf_s", os, 0);

    // Snapshot together with clear, then handshake corners.
    data = 32'h0; valid = 4'hF; tick();
    valid = 4'h7; tick();
    chk("pre_even_w", ew, 7);
    snap_req = 1'b1; clear = 1'b1; valid = 4'hF; tick();
    chk("sc_snap_even_w", sew, 7);
    chk("sc_snap_valid_w", svw, 1);
    chk("sc_even_w", ew, 0);
    chk("sc_snap_even_c", sec, 7);
    chk("sc_even_c", ec, 0);
    snap_req = 1'b0; clear = 1'b0; tick();
    chk("hold_even_w", ew, 4);
    chk("hold_valid_w", svw, 1);
    snap_req = 1'b1; tick();
    chk("hold_req_snap_w", sew, 7);
    chk("hold_req_valid_w", svw, 1);
    chk("hold_req_even_w", ew, 8);
    chk("hold_req_even_c", ec, 8);
    chk("hold_req_snap_c", sec, 7);
    snap_req = 1'b0; snap_ack = 1'b1; valid = 4'h0; tick();
    chk("ack_valid_w", svw, 0);
    chk("ack_valid_c", svc, 0);
    tick();
    chk("idle_ack_valid_w", svw, 0);
    snap_req = 1'b1; valid = 4'hF; tick();
    chk("recap_snap_w", sew, 8);
    chk("recap_valid_w", svw, 1);
    chk("recap_even_w", ew, 12);
    chk("recap_snap_c", sec, 8);
    chk("recap_even_c", ec, 0);
    chk("recap_valid_c", svc, 1);
    snap_req = 1'b0; snap_ack = 1'b0; valid = 4'h0;

    // Reset while a snapshot is held.
    rst = 1'b1; tick();
    chk("hrst_even_w", ew, 0);
    chk("hrst_match_w", mw, 0);
    chk("hrst_ovf_w", ow, 0);
    chk("hrst_snap_even_w", sew, 0);
    chk("hrst_snap_match_w", smw, 0);
    chk("hrst_snap_ovf_w", sow, 0);
    chk("hrst_valid_w", svw, 0);
    chk("hrst_valid_c", svc, 0);
    rst = 1'b0; tick();
    chk("post_rst_valid_w", svw, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
